puf_reconstruct_engine: RTL and testbench
=========================================

Name: puf_reconstruct_engine

Overview:
- Parametrised successor to the fixed 256-bit scramble/decode PUF datapath.
- Whitens a raw PUF response with a seeded 8-bit LFSR keystream and XORs in code-offset helper data. It then majority-decodes a REP-times repetition code to reconstruct a KEY_BITS-bit key.
- Processes one code group per cycle under a start/busy/done handshake, and reports the corrected-bit count plus a reliability fail flag.
- Sits between the PUF response capture and the key consumer.

Parameters:
KEY_BITS, 128, reconstructed key width; one group processed per cycle (>=1)
REP, 3, repetition factor; odd, >=3; response width N = KEY_BITS*REP
MAX_ERR, 16, fail threshold on total corrected bits

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = scramble only, 1 = scramble and decode; latched at start
seed  in  8  LFSR seed; latched at start; 8'h00 is replaced by 8'h01
data_in  in  N  raw response; latched at start
i_helper  in  N  helper data; latched at start
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse when results are valid
scr_out  out  N  scrambled response
key_out  out  KEY_BITS  reconstructed key
err_count  out  clog2(N+1)  number of corrected bits
fail  out  1  err_count > MAX_ERR (mode 1 only)

Behaviour:
Reset:
- Reset has priority over everything, including mid-RUN.
- All outputs go to 0, FSM goes to IDLE, and the LFSR state goes to 8'h01.
- A run aborted by reset yields no done pulse.

Keystream:
- Fibonacci LFSR, state s[7:0], polynomial x^8+x^6+x^5+x^4+1.
- Per step: output ks = s[7]; fb = s[7]^s[5]^s[4]^s[3]; s <= {s[6:0],fb}.
- Step 0 uses the latched seed.
- Bit j uses step j; bits are indexed from LSB.
- Each RUN cycle performs REP unrolled steps.

Group g (bits g*REP .. g*REP+REP-1), processed in RUN cycle g:
- scr[j] = data_in[j] ^ ks[j]
- c[j] = scr[j] ^ i_helper[j]
- key[g] = majority(c over the group)
- err_count += count of c bits in the group that differ from key[g]
- The count is saturation-free by width.

FSM:
- IDLE: start=1 latches mode, seed, data_in and i_helper, clears scr_out, key_out, err_count and fail, then goes to LOAD. start=0 stays in IDLE.
- LOAD (1 cycle): LFSR <= latched seed (or 8'h01 if the seed is 0), group counter <= 0, then goes to RUN.
- RUN (KEY_BITS cycles): processes group g and increments g. After g = KEY_BITS-1 it goes to DONE.
- DONE (1 cycle): done=1; fail = mode & (err_count > MAX_ERR). Goes to IDLE.

Latency and handshake:
- start accepted in cycle t gives done=1 in cycle t+KEY_BITS+2.
- start is ignored while busy or in DONE; no queuing.
- Inputs may change after the start cycle without effect.
- Outputs hold their values from DONE until the next accepted start.

Mode and output rules:
- mode 0: key_out, err_count and fail stay 0; scr_out is still computed.
- scr_out bits are written as their group is processed; only values at done are guaranteed.
- Simultaneous reset and start: reset wins.
- start held high continuously: a new run begins in the IDLE cycle after DONE.

Test Plan:
- Config KEY_BITS=4, REP=3, MAX_ERR=1; mode=1, seed=8'h01, data_in=0, i_helper=0. Expected keystream bits 0..11 = 0,0,0,0,0,0,0,1,0,0,0,1. Required: scr_out=12'h880, key_out=4'h0, err_count=2, fail=1, done exactly 6 cycles after start.
- Same config, i_helper=12'hFFF -> scr_out=12'h880, key_out=4'hF, err_count=2, fail=1.
- Same config, seed=8'h00 -> outputs identical to seed 8'h01.
- Same config, mode=0, i_helper=12'hFFF -> scr_out=12'h880, key_out=0, err_count=0, fail=0.
- Assert reset 2 cycles into RUN -> all outputs 0, no done pulse. A subsequent clean start reproduces the results of the first scenario.
- Pulse start again while busy -> ignored; exactly one done pulse. Then, default config (KEY_BITS=128) with a random data_in/seed and i_helper = scr_out of a prior mode-0 run XOR a random repetition-encoded key, plus 1 injected error per group in 10 groups -> key matches the encoded key, err_count=10, fail=0.

Source files
------------

// File: rtl/puf_reconstruct_engine_if.sv
// rtl/puf_reconstruct_engine_if.sv - start/done handshake and data bundle for the PUF key reconstruction engine
interface puf_reconstruct_engine_if #(
    parameter int KEY_BITS = 128,
    parameter int REP      = 3
);
    localparam int N  = KEY_BITS * REP;
    localparam int EW = $clog2(N + 1);

    logic                start;
    logic                mode;
    logic [7:0]          seed;
    logic [N-1:0]        data_in;
    logic [N-1:0]        i_helper;
    logic                busy;
    logic                done;
    logic [N-1:0]        scr_out;
    logic [KEY_BITS-1:0] key_out;
    logic [EW-1:0]       err_count;
    logic                fail;

    modport master (
        output start, mode, seed, data_in, i_helper,
        input  busy, done, scr_out, key_out, err_count, fail
    );

    modport slave (
        input  start, mode, seed, data_in, i_helper,
        output busy, done, scr_out, key_out, err_count, fail
    );
endinterface

// File: rtl/puf_reconstruct_engine.sv
// rtl/puf_reconstruct_engine.sv - LFSR whitening, code-offset helper XOR and repetition majority decode
module puf_reconstruct_engine #(
    parameter int KEY_BITS = 128,
    parameter int REP      = 3,
    parameter int MAX_ERR  = 16
) (
    input logic                     clk,
    input logic                     reset,
    puf_reconstruct_engine_if.slave bus
);
    localparam int N  = KEY_BITS * REP;
    localparam int EW = $clog2(N + 1);
    localparam int CW = $clog2(REP + 1);
    localparam int GW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t         state;
    logic           mode_q;
    logic [7:0]     seed_q;
    logic [N-1:0]   data_q;
    logic [N-1:0]   helper_q;
    logic [7:0]     lfsr;
    logic [7:0]     lfsr_adv;
    logic [GW-1:0]  grp;
    logic [REP-1:0] ks_grp;
    logic [REP-1:0] scr_grp;
    logic [REP-1:0] c_grp;
    logic [CW-1:0]  ones;
    logic [CW-1:0]  grp_err;
    logic           key_bit;
    logic [EW-1:0]  err_next;

    // REP keystream steps per cycle; the advanced state is what the next group starts from
    always_comb begin
        lfsr_adv = lfsr;
        ks_grp   = '0;
        for (int k = 0; k < REP; k++) begin
            ks_grp[k] = lfsr_adv[7];
            lfsr_adv  = {lfsr_adv[6:0], lfsr_adv[7] ^ lfsr_adv[5] ^ lfsr_adv[4] ^ lfsr_adv[3]};
        end
    end

    assign scr_grp = data_q[int'(grp) * REP +: REP] ^ ks_grp;
    assign c_grp   = scr_grp ^ helper_q[int'(grp) * REP +: REP];

    always_comb begin
        ones = '0;
        for (int k = 0; k < REP; k++) begin
            ones = ones + CW'(c_grp[k]);
        end
    end

    // REP is odd, so the majority is never a tie
    assign key_bit  = (ones > CW'(REP / 2));
    assign grp_err  = key_bit ? (CW'(REP) - ones) : ones;
    assign err_next = bus.err_count + EW'(grp_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            seed_q        <= 8'h00;
            data_q        <= '0;
            helper_q      <= '0;
            lfsr          <= 8'h01;
            grp           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.scr_out   <= '0;
            bus.key_out   <= '0;
            bus.err_count <= '0;
            bus.fail      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q        <= bus.mode;
                        seed_q        <= bus.seed;
                        data_q        <= bus.data_in;
                        helper_q      <= bus.i_helper;
                        bus.scr_out   <= '0;
                        bus.key_out   <= '0;
                        bus.err_count <= '0;
                        bus.fail      <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    lfsr  <= (seed_q == 8'h00) ? 8'h01 : seed_q;
                    grp   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    lfsr <= lfsr_adv;
                    bus.scr_out[int'(grp) * REP +: REP] <= scr_grp;
                    if (mode_q) begin
                        bus.key_out[grp] <= key_bit;
                        bus.err_count    <= err_next;
                    end
                    if (grp == GW'(KEY_BITS - 1)) begin
                        // fail uses the total including this last group so it is valid alongside done
                        bus.fail <= mode_q && (int'(err_next) > MAX_ERR);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        grp <= grp + GW'(1);
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_reconstruct_engine.sv
// tb/tb_puf_reconstruct_engine.sv - randomized self-checking bench for puf_reconstruct_engine
module tb_puf_reconstruct_engine;
    localparam int SK = 4,   SR = 3, SM = 1,  SN = 12;
    localparam int LK = 128, LR = 3, LM = 16, LN = 384;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    puf_reconstruct_engine_if #(.KEY_BITS(SK), .REP(SR)) bus_s ();
    puf_reconstruct_engine_if #(.KEY_BITS(LK), .REP(LR)) bus_l ();

    puf_reconstruct_engine #(.KEY_BITS(SK), .REP(SR), .MAX_ERR(SM)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s.slave));
    puf_reconstruct_engine #(.KEY_BITS(LK), .REP(LR), .MAX_ERR(LM)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l.slave));

    typedef struct {
        logic [LN-1:0] scr;
        logic [LK-1:0] key;
        int            err;
        logic          fail;
    } result_t;

    // Walk the keystream bit by bit, then decode each group by counting ones
    function automatic result_t model(int kb, int rep, int max_err, logic mode,
                                      logic [7:0] seed, logic [LN-1:0] d, logic [LN-1:0] h);
        result_t    r;
        logic [7:0] s;
        int         ones;
        r.scr = '0;
        r.key = '0;
        r.err = 0;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int j = 0; j < kb * rep; j++) begin
            r.scr[j] = d[j] ^ s[7];
            s = {s[6:0], ^(s & 8'hB8)};
        end
        if (mode) begin
            for (int g = 0; g < kb; g++) begin
                ones = 0;
                for (int i = 0; i < rep; i++) ones += int'(r.scr[g*rep+i] ^ h[g*rep+i]);
                r.key[g] = (2 * ones > rep);
                r.err += (ones < rep - ones) ? ones : rep - ones;
            end
        end
        r.fail = mode && (r.err > max_err);
        return r;
    endfunction

    function automatic logic [LN-1:0] rand_vec();
        logic [LN-1:0] v;
        for (int i = 0; i < LN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Start one small run; inputs are scrambled after the start cycle. lat = 0 on timeout.
    task automatic run_s(input logic mode, input logic [7:0] seed,
                         input logic [SN-1:0] d, input logic [SN-1:0] h, output int lat);
        @(posedge clk); #1;
        bus_s.mode = mode; bus_s.seed = seed; bus_s.data_in = d; bus_s.i_helper = h;
        bus_s.start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus_s.start = 1'b0; bus_s.mode = ~mode; bus_s.seed = 8'($urandom);
                bus_s.data_in = SN'($urandom); bus_s.i_helper = SN'($urandom);
            end
            if (bus_s.done) begin lat = c; break; end
        end
    endtask

    task automatic run_l(input logic mode, input logic [7:0] seed,
                         input logic [LN-1:0] d, input logic [LN-1:0] h, output int lat);
        @(posedge clk); #1;
        bus_l.mode = mode; bus_l.seed = seed; bus_l.data_in = d; bus_l.i_helper = h;
        bus_l.start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin bus_l.start = 1'b0; bus_l.data_in = rand_vec(); end
            if (bus_l.done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_s.scr_out, bus_s.key_out, bus_s.err_count, bus_s.fail, bus_s.busy, bus_s.done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got scr=%h key=%h err=%0d fail=%b busy=%b done=%b, want all 0",
                     bus_s.scr_out, bus_s.key_out, bus_s.err_count, bus_s.fail, bus_s.busy, bus_s.done);
        end
        reset = 1'b0;
    endtask

    task automatic test_plan_vectors();
        logic [7:0]    t_seed [4] = '{8'h01, 8'h01, 8'h00, 8'h01};
        logic          t_mode [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [SN-1:0] t_help [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
        logic [SK-1:0] t_key  [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
        int            t_err  [4] = '{2, 2, 2, 0};
        logic          t_fail [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_s(t_mode[i], t_seed[i], 12'h000, t_help[i], lat);
            n_checks++;
            if (lat !== 6) begin n_fail++; $display("FAIL plan%0d_latency: got %0d want 6", i, lat); end
            n_checks++;
            if (bus_s.scr_out !== 12'h880) begin n_fail++; $display("FAIL plan%0d_scr: got %h want 880", i, bus_s.scr_out); end
            n_checks++;
            if (bus_s.key_out !== t_key[i]) begin n_fail++; $display("FAIL plan%0d_key: got %h want %h", i, bus_s.key_out, t_key[i]); end
            n_checks++;
            if (int'(bus_s.err_count) !== t_err[i]) begin n_fail++; $display("FAIL plan%0d_err: got %0d want %0d", i, bus_s.err_count, t_err[i]); end
            n_checks++;
            if (bus_s.fail !== t_fail[i]) begin n_fail++; $display("FAIL plan%0d_fail: got %b want %b", i, bus_s.fail, t_fail[i]); end
            @(posedge clk); #1;
            n_checks++;
            if (bus_s.done !== 1'b0 || bus_s.scr_out !== 12'h880) begin
                n_fail++; $display("FAIL plan%0d_hold: got done=%b scr=%h want done=0 scr=880", i, bus_s.done, bus_s.scr_out);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        int lat;
        @(posedge clk); #1;
        bus_s.mode = 1'b1; bus_s.seed = 8'h01; bus_s.data_in = '0; bus_s.i_helper = 12'hFFF;
        bus_s.start = 1'b1;
        @(posedge clk); #1; bus_s.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({bus_s.scr_out, bus_s.key_out, bus_s.err_count, bus_s.fail, bus_s.busy, bus_s.done} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got key=%h err=%0d busy=%b, want all 0",
                     bus_s.key_out, bus_s.err_count, bus_s.busy);
        end
        for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (bus_s.done) dones++; end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses want 0", dones); end
        run_s(1'b1, 8'h01, 12'h000, 12'h000, lat);
        n_checks++;
        if (lat !== 6 || bus_s.scr_out !== 12'h880 || bus_s.key_out !== 4'h0 || bus_s.err_count !== 4'd2 || bus_s.fail !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_rerun: got lat=%0d scr=%h key=%h err=%0d fail=%b want 6/880/0/2/1",
                     lat, bus_s.scr_out, bus_s.key_out, bus_s.err_count, bus_s.fail);
        end
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        @(posedge clk); #1;
        bus_s.mode = 1'b1; bus_s.seed = 8'h01; bus_s.data_in = '0; bus_s.i_helper = 12'hFFF;
        bus_s.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus_s.start = (c == 3);
            if (c == 3) begin bus_s.mode = 1'b0; bus_s.i_helper = 12'h000; bus_s.data_in = 12'h5A5; end
            if (bus_s.done) begin
                dones++;
                n_checks++;
                if (bus_s.key_out !== 4'hF || bus_s.err_count !== 4'd2) begin
                    n_fail++; $display("FAIL busy_result: got key=%h err=%0d want F/2", bus_s.key_out, bus_s.err_count);
                end
            end
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_back_to_back();
        int first = 0, second = 0;
        @(posedge clk); #1;
        bus_s.mode = 1'b1; bus_s.seed = 8'h01; bus_s.data_in = '0; bus_s.i_helper = '0;
        bus_s.start = 1'b1;
        for (int c = 1; c <= 30 && second == 0; c++) begin
            @(posedge clk); #1;
            if (bus_s.done) begin
                if (first == 0) first = c;
                else begin second = c; bus_s.start = 1'b0; end
            end
        end
        bus_s.start = 1'b0;
        n_checks++;
        if (first !== 6 || second !== 13) begin
            n_fail++; $display("FAIL back_to_back_timing: got done at %0d,%0d want 6,13", first, second);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random_small();
        result_t       e;
        logic [SN-1:0] d, h;
        logic [7:0]    sd;
        logic          m;
        int            lat;
        for (int i = 0; i < 8; i++) begin
            d = SN'($urandom); h = SN'($urandom); m = 1'($urandom);
            sd = (i == 0) ? 8'h00 : 8'($urandom);
            e = model(SK, SR, SM, m, sd, LN'(d), LN'(h));
            run_s(m, sd, d, h, lat);
            n_checks++;
            if (lat !== 6 || bus_s.scr_out !== e.scr[SN-1:0] || bus_s.key_out !== e.key[SK-1:0]
                || int'(bus_s.err_count) !== e.err || bus_s.fail !== e.fail) begin
                n_fail++;
                $display("FAIL random_small%0d: got lat=%0d scr=%h key=%h err=%0d fail=%b want 6/%h/%h/%0d/%b",
                         i, lat, bus_s.scr_out, bus_s.key_out, bus_s.err_count, bus_s.fail,
                         e.scr[SN-1:0], e.key[SK-1:0], e.err, e.fail);
            end
        end
    endtask

    task automatic test_large();
        logic [LN-1:0] d, cw, emask, scr0;
        logic [LK-1:0] key;
        logic [7:0]    sd;
        result_t       e;
        int            lat, g;
        d = rand_vec(); sd = 8'($urandom);
        key = rand_vec()[LK-1:0];
        e = model(LK, LR, LM, 1'b0, sd, d, '0);
        run_l(1'b0, sd, d, rand_vec(), lat);
        scr0 = bus_l.scr_out;
        n_checks++;
        if (lat !== LK + 2 || scr0 !== e.scr || bus_l.key_out !== '0 || bus_l.err_count !== '0 || bus_l.fail !== 1'b0) begin
            n_fail++; $display("FAIL large_mode0: got lat=%0d err=%0d scr=%h want lat=%0d scr=%h", lat, bus_l.err_count, scr0, LK + 2, e.scr);
        end
        cw = '0; emask = '0;
        for (int i = 0; i < LK; i++) for (int r = 0; r < LR; r++) cw[i*LR+r] = key[i];
        for (int i = 0; i < 10; i++) begin
            g = i * 12 + int'($urandom_range(11, 0));
            emask[g*LR + int'($urandom_range(LR - 1, 0))] = 1'b1;
        end
        run_l(1'b1, sd, d, scr0 ^ cw ^ emask, lat);
        n_checks++;
        if (bus_l.key_out !== key) begin n_fail++; $display("FAIL large_key: got %h want %h", bus_l.key_out, key); end
        n_checks++;
        if (bus_l.err_count !== 9'd10 || bus_l.fail !== 1'b0 || lat !== LK + 2) begin
            n_fail++; $display("FAIL large_err: got err=%0d fail=%b lat=%0d want 10/0/%0d", bus_l.err_count, bus_l.fail, lat, LK + 2);
        end
        n_checks++;
        if (bus_l.scr_out !== scr0) begin n_fail++; $display("FAIL large_scr: got %h want %h", bus_l.scr_out, scr0); end
    endtask

    initial begin
        bus_s.start = 1'b0; bus_s.mode = 1'b0; bus_s.seed = '0; bus_s.data_in = '0; bus_s.i_helper = '0;
        bus_l.start = 1'b0; bus_l.mode = 1'b0; bus_l.seed = '0; bus_l.data_in = '0; bus_l.i_helper = '0;
        test_reset();
        test_plan_vectors();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        test_random_small();
        test_large();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
